// File: rtl/bin_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with valid/ready handshakes.
// Optional leading-zero blanking output enabled by defining BIN_BCD_LZB_EN.
module bin_bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      in_bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  ovf,
  output logic                  busy
`ifdef BIN_BCD_LZB_EN
  ,
  output logic [DIGITS-1:0]     blank
`endif
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   res_q, res_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               finish;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // The carry out of the top digit is dropped from the result and only recorded in ovf.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    res_d   = res_q;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          bin_d   = in_bin;
          bcd_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = CNT_W'(BIN_W);
          state_d = CONV;
        end
      end
      CONV: begin
        bcd_d = {adj[BCD_W-2:0], bin_q[BIN_W-1]};
        bin_d = {bin_q[BIN_W-2:0], 1'b0};
        ovf_d = ovf_q | adj[BCD_W-1];
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          finish  = 1'b1;
          res_d   = {adj[BCD_W-2:0], bin_q[BIN_W-1]};
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_bcd   = res_q;
  assign ovf       = ovf_q;

`ifdef BIN_BCD_LZB_EN
  logic [DIGITS-1:0] blank_q, blank_d;
  logic              allZero;

  // Scan from the top digit down; the units digit is never blanked.
  always_comb begin
    blank_d = '0;
    allZero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      allZero    = allZero & (res_d[4*i +: 4] == 4'd0);
      blank_d[i] = allZero;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_q <= '0;
    end else if (finish) begin
      blank_q <= blank_d;
    end
  end

  assign blank = blank_q;
`endif

endmodule

// File: tb/tb_bin_bcd_seq.sv
// Directed bench for bin_bcd_seq: three instances (8b/3d, 4b/2d, 8b/2d) sharing clock and reset.
module tb_bin_bcd_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       outReady;
  logic [7:0] inBin;
  logic [2:0] inValid;

  int checkCount = 0;
  int errorCount = 0;
  int curSel = 0;

  logic        inReadyA, outValidA, ovfA, busyA;
  logic [11:0] outBcdA;
  logic        inReadyB, outValidB, ovfB, busyB;
  logic [7:0]  outBcdB;
  logic        inReadyC, outValidC, ovfC, busyC;
  logic [7:0]  outBcdC;
`ifdef BIN_BCD_LZB_EN
  logic [2:0]  blankA;
  logic [1:0]  blankB, blankC;
`endif

  logic        selReady, selValid, selOvf, selBusy;
  logic [11:0] selBcd;

  always #5 clk = ~clk;

  bin_bcd_seq #(.BIN_W(8), .DIGITS(3)) dutA (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid[0]), .in_ready(inReadyA),
    .in_bin(inBin), .out_valid(outValidA), .out_ready(outReady),
    .out_bcd(outBcdA), .ovf(ovfA), .busy(busyA)
`ifdef BIN_BCD_LZB_EN
    , .blank(blankA)
`endif
  );

  bin_bcd_seq #(.BIN_W(4), .DIGITS(2)) dutB (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid[1]), .in_ready(inReadyB),
    .in_bin(inBin[3:0]), .out_valid(outValidB), .out_ready(outReady),
    .out_bcd(outBcdB), .ovf(ovfB), .busy(busyB)
`ifdef BIN_BCD_LZB_EN
    , .blank(blankB)
`endif
  );

  bin_bcd_seq #(.BIN_W(8), .DIGITS(2)) dutC (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid[2]), .in_ready(inReadyC),
    .in_bin(inBin), .out_valid(outValidC), .out_ready(outReady),
    .out_bcd(outBcdC), .ovf(ovfC), .busy(busyC)
`ifdef BIN_BCD_LZB_EN
    , .blank(blankC)
`endif
  );

  // Route the currently selected instance onto one set of observation signals.
  always_comb begin
    selReady = inReadyA;
    selValid = outValidA;
    selOvf   = ovfA;
    selBusy  = busyA;
    selBcd   = outBcdA;
    if (curSel == 1) begin
      selReady = inReadyB;
      selValid = outValidB;
      selOvf   = ovfB;
      selBusy  = busyB;
      selBcd   = {4'h0, outBcdB};
    end else if (curSel == 2) begin
      selReady = inReadyC;
      selValid = outValidC;
      selOvf   = ovfC;
      selBusy  = busyC;
      selBcd   = {4'h0, outBcdC};
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
    end
  endtask

  task automatic startConv(input int sel, input logic [7:0] value);
    int waitCycles;
    waitCycles = 0;
    curSel = sel;
    @(negedge clk);
    while (!selReady && waitCycles < 100) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput("inReadyBeforeOffer", {31'd0, selReady}, 32'd1);
    inBin = value;
    inValid[sel] = 1'b1;
    @(posedge clk);
    #1;
    inValid = '0;
  endtask

  task automatic waitResult(input int expLat);
    int lat;
    lat = 0;
    while (!selValid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("latency", lat, expLat);
  endtask

  task automatic applyStimulus(input int sel, input logic [7:0] value,
                               input logic [11:0] expBcd, input logic expOvf, input string tag);
    startConv(sel, value);
    waitResult((sel == 1) ? 4 : 8);
    checkOutput({tag, ".bcd"}, {20'd0, selBcd}, {20'd0, expBcd});
    checkOutput({tag, ".ovf"}, {31'd0, selOvf}, {31'd0, expOvf});
  endtask

  initial begin
    rst_n    = 1'b0;
    outReady = 1'b1;
    inValid  = '0;
    inBin    = '0;
    #12;
    checkOutput("rst.inReady", {31'd0, inReadyA}, 32'd1);
    checkOutput("rst.outValid", {31'd0, outValidA}, 32'd0);
    checkOutput("rst.outBcd", {20'd0, outBcdA}, 32'd0);
    checkOutput("rst.ovf", {31'd0, ovfA}, 32'd0);
    checkOutput("rst.busy", {31'd0, busyA}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(0, 8'd255, 12'h255, 1'b0, "A255");
`ifdef BIN_BCD_LZB_EN
    checkOutput("blank255", {29'd0, blankA}, 32'b000);
`endif
    applyStimulus(0, 8'd0, 12'h000, 1'b0, "A0");
`ifdef BIN_BCD_LZB_EN
    checkOutput("blank0", {29'd0, blankA}, 32'b110);
`endif
    applyStimulus(0, 8'd10, 12'h010, 1'b0, "A10");
`ifdef BIN_BCD_LZB_EN
    checkOutput("blank10", {29'd0, blankA}, 32'b100);
`endif
    applyStimulus(0, 8'd7, 12'h007, 1'b0, "A7");
`ifdef BIN_BCD_LZB_EN
    checkOutput("blank7", {29'd0, blankA}, 32'b110);
`endif
    applyStimulus(0, 8'd42, 12'h042, 1'b0, "A42");
`ifdef BIN_BCD_LZB_EN
    checkOutput("blank42", {29'd0, blankA}, 32'b100);
`endif

    for (int v = 0; v < 16; v++) begin
      applyStimulus(1, 8'(v), 12'(((v / 10) << 4) | (v % 10)), 1'b0, $sformatf("B%0d", v));
    end

    applyStimulus(2, 8'd99, 12'h099, 1'b0, "C99");
    applyStimulus(2, 8'd255, 12'h055, 1'b1, "C255");
    applyStimulus(2, 8'd7, 12'h007, 1'b0, "C7");

    // Hold the result under backpressure and try to sneak in another operand.
    outReady = 1'b0;
    startConv(0, 8'd123);
    waitResult(8);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("bp.outValid", {31'd0, outValidA}, 32'd1);
      checkOutput("bp.outBcd", {20'd0, outBcdA}, 32'h123);
      checkOutput("bp.ovf", {31'd0, ovfA}, 32'd0);
      checkOutput("bp.inReady", {31'd0, inReadyA}, 32'd0);
      checkOutput("bp.busy", {31'd0, busyA}, 32'd1);
      if (i == 5) begin
        inBin = 8'd77;
        inValid[0] = 1'b1;
      end else begin
        inValid = '0;
      end
    end
    outReady = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rel.outValid", {31'd0, outValidA}, 32'd0);
    checkOutput("rel.inReady", {31'd0, inReadyA}, 32'd1);
    checkOutput("rel.outBcdHeld", {20'd0, outBcdA}, 32'h123);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rel.notQueued", {31'd0, busyA}, 32'd0);

    startConv(0, 8'd200);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midRst.inReady", {31'd0, inReadyA}, 32'd1);
    checkOutput("midRst.outValid", {31'd0, outValidA}, 32'd0);
    checkOutput("midRst.outBcd", {20'd0, outBcdA}, 32'd0);
    checkOutput("midRst.ovf", {31'd0, ovfA}, 32'd0);
    checkOutput("midRst.busy", {31'd0, busyA}, 32'd0);
`ifdef BIN_BCD_LZB_EN
    checkOutput("midRst.blank", {29'd0, blankA}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 8'd42, 12'h042, 1'b0, "postRst42");

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
